// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset defaults and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam int unsigned PC_W     = 16;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned COUNT_W  = 16;

   localparam logic [PC_W-1:0]     RESET_PC_DEF    = 16'h0000;
   localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'b1111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset clears everything, flush drops only valid,
// hold freezes the slot, otherwise load captures or the slot becomes a bubble.
module fetch_stage_if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = PC_W,
   parameter int unsigned INSTR_WIDTH = INSTR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   hold,
   input  logic                   load,
   input  logic [INSTR_WIDTH-1:0] next_instr,
   input  logic [PC_WIDTH-1:0]    next_pc,
   input  logic [PC_WIDTH-1:0]    next_pc_plus2,
   output logic                   valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [PC_WIDTH-1:0]    pc_plus2
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         instr    <= '0;
         pc       <= '0;
         pc_plus2 <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (!hold) begin
         if (load) begin
            valid    <= 1'b1;
            instr    <= next_instr;
            pc       <= next_pc;
            pc_plus2 <= next_pc_plus2;
         end else begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the RUN/HALT state and the fetch counter,
// and feeds the IF/ID register from the combinational instruction memory.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned          PC_WIDTH    = PC_W,
   parameter int unsigned          INSTR_WIDTH = INSTR_W,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = RESET_PC_DEF,
   parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_WIDTH-1:0]    imem_pc,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   ifid_valid,
   output logic [INSTR_WIDTH-1:0] ifid_instr,
   output logic [PC_WIDTH-1:0]    ifid_pc,
   output logic [PC_WIDTH-1:0]    ifid_pc_plus2,
   output logic                   halted,
   output logic [COUNT_W-1:0]     fetch_count
);

   fetch_state_e          state_q;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [PC_WIDTH-1:0]   pc_next_seq;
   logic [COUNT_W-1:0]    count_q;
   logic                  is_halt_op;
   logic                  in_run;

   assign pc_next_seq = pc_q + PC_WIDTH'(2);
   assign is_halt_op  = (imem_instr[INSTR_WIDTH-1 -: OPCODE_W] == HALT_OPCODE);
   assign in_run      = (state_q == ST_RUN);

   assign imem_pc     = pc_q;
   assign halted      = (state_q == ST_HALT);
   assign fetch_count = count_q;

   // PC, state and counter; priority rst > redirect > stall > state action
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
         count_q <= '0;
      end else if (redirect_valid) begin
         pc_q    <= {redirect_pc[PC_WIDTH-1:1], 1'b0};
         state_q <= ST_RUN;
      end else if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if (count_q != '1) begin
                  count_q <= count_q + COUNT_W'(1);
               end
               if (is_halt_op) begin
                  state_q <= ST_HALT;
               end else begin
                  pc_q <= pc_next_seq;
               end
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   fetch_stage_if_id_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_if_id_reg (
      .clk           (clk),
      .rst           (rst),
      .flush         (redirect_valid),
      .hold          (stall),
      .load          (in_run),
      .next_instr    (imem_instr),
      .next_pc       (pc_q),
      .next_pc_plus2 (pc_next_seq),
      .valid         (ifid_valid),
      .instr         (ifid_instr),
      .pc            (ifid_pc),
      .pc_plus2      (ifid_pc_plus2)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small behavioural instruction memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_pc;
   logic [15:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc_plus2;
   logic        halted;
   logic [15:0] fetch_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:15];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_pc_plus2  (ifid_pc_plus2),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   // Program: 0:1000 2:2000 4:3000 6:F000(HALT) 8:5000, FFFE:7777, others 4xxx
   always_comb begin
      if (imem_pc == 16'hFFFE)     imem_instr = 16'h7777;
      else if (imem_pc < 16'd32)   imem_instr = mem[imem_pc[4:1]];
      else                         imem_instr = 16'h4EEE;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic v, input logic [15:0] instr,
                             input logic [15:0] pc, input logic [15:0] plus2,
                             input logic [15:0] ipc, input logic [15:0] cnt, input logic h);
      check({tag, ".valid"},  32'(ifid_valid),    32'(v));
      check({tag, ".instr"},  32'(ifid_instr),    32'(instr));
      check({tag, ".pc"},     32'(ifid_pc),       32'(pc));
      check({tag, ".plus2"},  32'(ifid_pc_plus2), 32'(plus2));
      check({tag, ".imempc"}, 32'(imem_pc),       32'(ipc));
      check({tag, ".count"},  32'(fetch_count),   32'(cnt));
      check({tag, ".halted"}, 32'(halted),        32'(h));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h4000 + 16'(i);
      mem[0] = 16'h1000;
      mem[1] = 16'h2000;
      mem[2] = 16'h3000;
      mem[3] = 16'hF000;
      mem[4] = 16'h5000;

      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
      tick();
      expect_all("rst", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd0, 1'b0);
      rst = 1'b0;

      // straight-line fetch
      tick(); expect_all("f0", 1'b1, 16'h1000, 16'h0, 16'h2, 16'h2, 16'd1, 1'b0);
      tick(); expect_all("f2", 1'b1, 16'h2000, 16'h2, 16'h4, 16'h4, 16'd2, 1'b0);

      // stall three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); expect_all($sformatf("stall%0d", i), 1'b1, 16'h2000, 16'h2, 16'h4, 16'h4, 16'd2, 1'b0);
      end
      stall = 1'b0;
      tick(); expect_all("f4", 1'b1, 16'h3000, 16'h4, 16'h6, 16'h6, 16'd3, 1'b0);

      // HALT delivered once, then bubbles with PC parked
      tick(); expect_all("halt_op", 1'b1, 16'hF000, 16'h6, 16'h8, 16'h6, 16'd4, 1'b1);
      tick(); expect_all("halt_idle", 1'b0, 16'hF000, 16'h6, 16'h8, 16'h6, 16'd4, 1'b1);

      // redirect overrides stall, bit 0 dropped, leaves HALT
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0009;
      tick(); expect_all("redir9", 1'b0, 16'hF000, 16'h6, 16'h8, 16'h8, 16'd4, 1'b0);
      stall = 1'b0; redirect_valid = 1'b0;
      tick(); expect_all("f8", 1'b1, 16'h5000, 16'h8, 16'hA, 16'hA, 16'd5, 1'b0);

      // wrap at top of address space
      redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      tick(); expect_all("redirFFFE", 1'b0, 16'h5000, 16'h8, 16'hA, 16'hFFFE, 16'd5, 1'b0);
      redirect_valid = 1'b0;
      tick(); expect_all("fFFFE", 1'b1, 16'h7777, 16'hFFFE, 16'h0, 16'h0, 16'd6, 1'b0);
      tick(); expect_all("fwrap0", 1'b1, 16'h1000, 16'h0, 16'h2, 16'h2, 16'd7, 1'b0);

      // run into HALT again, then redirect to 0 refetches
      tick(); tick();
      tick(); expect_all("halt2", 1'b1, 16'hF000, 16'h6, 16'h8, 16'h6, 16'd10, 1'b1);
      tick(); expect_all("halt2_idle", 1'b0, 16'hF000, 16'h6, 16'h8, 16'h6, 16'd10, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 16'h0000;
      tick(); expect_all("redir0", 1'b0, 16'hF000, 16'h6, 16'h8, 16'h0, 16'd10, 1'b0);
      redirect_valid = 1'b0;
      tick(); expect_all("refetch0", 1'b1, 16'h1000, 16'h0, 16'h2, 16'h2, 16'd11, 1'b0);

      // reach HALT with fetch_count == 5, then reset in HALT
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 16'h0002;
      tick(); redirect_valid = 1'b0;
      tick(); tick(); tick();
      expect_all("halt5", 1'b1, 16'hF000, 16'h6, 16'h8, 16'h6, 16'd5, 1'b1);
      tick();
      rst = 1'b1;
      tick(); expect_all("rst_halt", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd0, 1'b0);
      rst = 1'b0;
      tick(); expect_all("post_rst", 1'b1, 16'h1000, 16'h0, 16'h2, 16'h2, 16'd1, 1'b0);

      // reset during a stall wins
      stall = 1'b1; rst = 1'b1;
      tick(); expect_all("rst_stall", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd0, 1'b0);
      rst = 1'b0; stall = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
